ifmux_drr_sched: RTL
====================

Name: ifmux_drr_sched

Overview:
Deficit-round-robin ingress scheduler for the 4-port interface mux. It decides which MAC rx port may move its next frame into the shared switch-core data/ptr FIFOs, replacing plain round-robin with byte-fair weighted arbitration. It watches per-port ptr-FIFO non-empty flags and head-of-line frame lengths, then issues a one-hot grant. The mux acknowledges the grant and reports completion when the frame has been moved.

Parameters:
NPORT, 4, number of requesters (fixed at 4; gnt_bin width 2)
LEN_W, 13, frame length field width (ptr word bits [12:0])
QNT_W, 13, per-port quantum width
DEF_W, 14, deficit counter width; saturating

Ports:
clk_sys  in  1  system clock
rstn_sys  in  1  reset, asynchronous, active-low
rx_rdy  in  4  per-port ptr FIFO non-empty (bit p = port p)
rx_len  in  4*LEN_W  head-of-line frame length per port, FWFT-valid while rx_rdy[p]; port p at [p*LEN_W +: LEN_W]
quantum  in  4*QNT_W  per-port quantum in bytes; static config, sampled when added
bp  in  1  downstream backpressure (shared FIFO near-full or ptr FIFO full)
gnt_vld  out  1  grant valid; held until gnt_ack
gnt_vec  out  4  one-hot granted port
gnt_bin  out  2  binary granted port
gnt_len  out  LEN_W  length of granted frame, captured at grant
gnt_ack  in  1  mux accepted grant (transfer started)
xfer_done  in  1  single-cycle pulse, granted frame fully transferred
busy  out  1  high in GRANT or BUSY

Behaviour:
- Reset: state=IDLE, ptr=0, fresh=1, all deficit[p]=0, gnt_vld=0, gnt_vec=0, gnt_bin=0, gnt_len=0, busy=0.
- Internal: ptr (2b round pointer, wraps 3->0), fresh (quantum not yet added on this visit), deficit[0..3] (DEF_W each), gnt_len register.
- IDLE: go to SCAN when rx_rdy!=0 and !bp. ptr, fresh and deficits are held.
- SCAN evaluates port p=ptr once per cycle, in priority order:
  a) !rx_rdy[p]: deficit[p]<=0; ptr<=p+1; fresh<=1. If rx_rdy==0 overall, go to IDLE.
  b) fresh: deficit[p]<=min(deficit[p]+quantum[p], 2^DEF_W-1); fresh<=0; ptr is held.
  c) deficit[p]>=rx_len[p] and !bp: go to GRANT; gnt_vec<=1<<p; gnt_bin<=p; gnt_len<=rx_len[p]; gnt_vld<=1.
  d) deficit[p]>=rx_len[p] and bp: stay in SCAN; ptr, fresh and deficit are held.
  e) otherwise: ptr<=p+1; fresh<=1; deficit is retained.
- GRANT: gnt_vld/gnt_vec/gnt_bin/gnt_len stay stable until gnt_ack. On gnt_ack: gnt_vld<=0; deficit[p]<=deficit[p]-gnt_len (cannot underflow); go to BUSY. rx_rdy/bp changes are ignored in GRANT.
- BUSY: wait for xfer_done, then go to SCAN on the same port with fresh=0, so further frames from that port are served within the remaining deficit. gnt_vec/gnt_bin hold their value through BUSY for the mux data select. They clear to 0 on exit.
- gnt_ack outside GRANT and xfer_done outside BUSY are ignored.
- xfer_done arriving in the same cycle as gnt_ack is ignored; BUSY requires a later pulse.
- Latency: from IDLE with rx_rdy[p] rising, ptr=p, fresh=1, quantum>=len: gnt_vld is high after the 3rd clock edge (IDLE->SCAN, add, grant).
- quantum[p]=0: port p is never granted unless rx_len=0. A zero-length frame is granted like any other frame.
- Saturated deficit: if rx_len[p] exceeds 2^DEF_W-1 the port stalls. This is a configuration error and is not detected.
- Async reset mid-operation forces the reset values immediately. No partial grant survives.

Test Plan:
1. Reset, then port0 only rdy, quantum0=1518, len=64 -> gnt_vld after 3 edges, gnt_vec=0001, gnt_bin=0, gnt_len=64. Ack + xfer_done, second 64B frame -> granted 1 cycle after return to SCAN with no quantum re-add (deficit 1454->1390).
2. All 4 ports backlogged with 1500B frames, quanta 1500/3000/1500/1500 -> grant order 0,1,1,2,3 repeating. Over 20 grants, port1 receives 8.
3. Port2 only, quantum 500, len 1400 -> granted on its 3rd visit (deficit 1500); after ack, residual deficit 100 is shown by the next 1400B frame needing 3 more visits.
4. Port3 accumulates deficit 400, then rx_rdy[3] drops; next visit -> deficit cleared. On re-arrival with len 500 and quantum 500 -> grant after 1 visit, not earlier.
5. bp high while port0 is eligible -> gnt_vld stays 0 for 10 cycles. bp low -> gnt_vld next edge. bp rising during GRANT/BUSY -> grant unaffected.
6. Async reset asserted in BUSY -> all outputs 0 immediately. After release, state IDLE and deficits 0, and scenario 1 repeats with identical timing.

Source files
------------

// File: rtl/ifmux_drr_sched_if.sv
// ifmux_drr_sched_if: scheduler <-> mux handshake bundle.
// master = scheduler (drives grant/busy), slave = mux/rx side.
interface ifmux_drr_sched_if #(
  parameter int LEN_W = 13,
  parameter int QNT_W = 13
);
  logic [3:0]         rx_rdy;
  logic [4*LEN_W-1:0] rx_len;
  logic [4*QNT_W-1:0] quantum;
  logic               bp;
  logic               gnt_vld;
  logic [3:0]         gnt_vec;
  logic [1:0]         gnt_bin;
  logic [LEN_W-1:0]   gnt_len;
  logic               gnt_ack;
  logic               xfer_done;
  logic               busy;

  modport master (
    input  rx_rdy, rx_len, quantum, bp,
    input  gnt_ack, xfer_done,
    output gnt_vld, gnt_vec, gnt_bin,
    output gnt_len, busy
  );

  modport slave (
    output rx_rdy, rx_len, quantum, bp,
    output gnt_ack, xfer_done,
    input  gnt_vld, gnt_vec, gnt_bin,
    input  gnt_len, busy
  );
endinterface

// File: rtl/ifmux_drr_sched.sv
// ifmux_drr_sched: deficit-round-robin ingress scheduler for the 4-port mux.
// Ports: clk_sys, rstn_sys (async low); bus = ifmux_drr_sched_if.master.
module ifmux_drr_sched #(
  parameter int NPORT = 4,
  parameter int LEN_W = 13,
  parameter int QNT_W = 13,
  parameter int DEF_W = 14
) (
  input  logic               clk_sys,
  input  logic               rstn_sys,
  ifmux_drr_sched_if.master  bus
);

  localparam int PW = $clog2(NPORT);
  localparam int SW = DEF_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_GRANT,
    ST_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             fresh_q, fresh_d;
  logic [DEF_W-1:0] def_q [NPORT];
  logic [DEF_W-1:0] def_d [NPORT];
  logic             gnt_vld_q, gnt_vld_d;
  logic [NPORT-1:0] gnt_vec_q, gnt_vec_d;
  logic [PW-1:0]    gnt_bin_q, gnt_bin_d;
  logic [LEN_W-1:0] gnt_len_q, gnt_len_d;
  logic             busy;

  logic             rdy_p;
  logic [LEN_W-1:0] len_p;
  logic [QNT_W-1:0] qnt_p;
  logic [DEF_W-1:0] def_p;
  logic [SW-1:0]    def_sum;
  logic [DEF_W-1:0] def_add;
  logic             fit;
  logic             sc_clr;
  logic             sc_add;
  logic             sc_gnt;
  logic             sc_next;

  assign rdy_p = bus.rx_rdy[ptr_q];
  assign len_p = bus.rx_len[int'(ptr_q)*LEN_W +: LEN_W];
  assign qnt_p = bus.quantum[int'(ptr_q)*QNT_W +: QNT_W];
  assign def_p = def_q[ptr_q];

  // Quantum add saturates at all-ones instead of wrapping.
  assign def_sum = {1'b0, def_p} + SW'(qnt_p);
  assign def_add = def_sum[DEF_W] ? '1 : def_sum[DEF_W-1:0];
  assign fit     = def_p >= DEF_W'(len_p);

  // Mutually exclusive SCAN actions; eligible+bp matches none and holds.
  assign sc_clr  = !rdy_p;
  assign sc_add  = rdy_p && fresh_q;
  assign sc_gnt  = rdy_p && !fresh_q && fit && !bus.bp;
  assign sc_next = rdy_p && !fresh_q && !fit;

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((|bus.rx_rdy) && !bus.bp)
          state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (sc_clr && !(|bus.rx_rdy))
          state_d = ST_IDLE;
        else if (sc_gnt)
          state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (bus.gnt_ack)
          state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.xfer_done)
          state_d = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    fresh_d   = fresh_q;
    def_d     = def_q;
    gnt_vld_d = gnt_vld_q;
    gnt_vec_d = gnt_vec_q;
    gnt_bin_d = gnt_bin_q;
    gnt_len_d = gnt_len_q;
    busy      = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        unique case (1'b1)
          sc_clr: begin
            def_d[ptr_q] = '0;
            ptr_d        = ptr_q + PW'(1);
            fresh_d      = 1'b1;
          end
          sc_add: begin
            def_d[ptr_q] = def_add;
            fresh_d      = 1'b0;
          end
          sc_gnt: begin
            gnt_vld_d        = 1'b1;
            gnt_vec_d        = '0;
            gnt_vec_d[ptr_q] = 1'b1;
            gnt_bin_d        = ptr_q;
            gnt_len_d        = len_p;
          end
          sc_next: begin
            ptr_d   = ptr_q + PW'(1);
            fresh_d = 1'b1;
          end
          default: ;
        endcase
      end
      ST_GRANT: begin
        busy = 1'b1;
        if (bus.gnt_ack) begin
          gnt_vld_d = 1'b0;
          // Grant required deficit >= len, so this never wraps.
          def_d[gnt_bin_q] = def_q[gnt_bin_q]
                           - DEF_W'(gnt_len_q);
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (bus.xfer_done) begin
          // Re-enter SCAN on the same port without a new quantum.
          fresh_d   = 1'b0;
          gnt_vec_d = '0;
          gnt_bin_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      ptr_q     <= '0;
      fresh_q   <= 1'b1;
      for (int i = 0; i < NPORT; i++)
        def_q[i] <= '0;
      gnt_vld_q <= 1'b0;
      gnt_vec_q <= '0;
      gnt_bin_q <= '0;
      gnt_len_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      fresh_q   <= fresh_d;
      def_q     <= def_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_vec_q <= gnt_vec_d;
      gnt_bin_q <= gnt_bin_d;
      gnt_len_q <= gnt_len_d;
    end
  end

  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_vec = gnt_vec_q;
  assign bus.gnt_bin = gnt_bin_q;
  assign bus.gnt_len = gnt_len_q;
  assign bus.busy    = busy;

endmodule
